// File: rtl/rf_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter slice.
// Carries the register bus width (REG_BUS), the zero word (ZERO_WORD), the
// register index width (RF_ADDR_BUS) and the grant encoding.
// Optional feature macro used by this slice: RF_WPORT_BYPASS_EN.
package rf_wport_arbiter_pkg;

    // REG_BUS: architectural register width
    localparam int unsigned REG_BUS_W = 64;
    // RF_ADDR_BUS: register index width
    localparam int unsigned RF_ADDR_BUS_W = 5;
    // ZERO_WORD: all-zero register value
    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

    // Which writeback source owns the write port this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_S0   = 2'd1,
        GNT_S1   = 2'd2
    } grant_e;

    // FIFO depth must be a power of two and at least 2
    function automatic logic depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: two writeback
// request channels, the registered write port and the hazard query pair.
// The slave modport is the arbiter side; master is the issue/regfile side.
// With RF_WPORT_BYPASS_EN defined, the forwarding outputs are added.
interface rf_wport_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 64
);
    logic              s0_valid;
    logic              s0_ready;
    logic [ADDR_W-1:0] s0_addr;
    logic [DATA_W-1:0] s0_data;
    logic              s1_valid;
    logic              s1_ready;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;
    logic              w_ena;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] q_addr1;
    logic [ADDR_W-1:0] q_addr2;
    logic              q_pend1;
    logic              q_pend2;
    logic              busy;
`ifdef RF_WPORT_BYPASS_EN
    logic              byp_hit1;
    logic              byp_hit2;
    logic [DATA_W-1:0] byp_data1;
    logic [DATA_W-1:0] byp_data2;
`endif

    modport slave (
        input  s0_valid, s0_addr, s0_data,
        input  s1_valid, s1_addr, s1_data,
        input  q_addr1, q_addr2,
        output s0_ready, s1_ready,
        output w_ena, w_addr, w_data,
        output q_pend1, q_pend2, busy
`ifdef RF_WPORT_BYPASS_EN
        , output byp_hit1, byp_hit2, byp_data1, byp_data2
`endif
    );

    modport master (
        output s0_valid, s0_addr, s0_data,
        output s1_valid, s1_addr, s1_data,
        output q_addr1, q_addr2,
        input  s0_ready, s1_ready,
        input  w_ena, w_addr, w_data,
        input  q_pend1, q_pend2, busy
`ifdef RF_WPORT_BYPASS_EN
        , input byp_hit1, byp_hit2, byp_data1, byp_data2
`endif
    );

endinterface

// File: rtl/rf_wport_arbiter_fifo.sv
// rf_wb_fifo: small in-order writeback FIFO for one source.
// Exposes the head entry, empty/full, and per-slot valid/address vectors
// so the parent can compare hazard queries against every queued write.
// A push into a full FIFO is dropped even if a pop happens the same cycle.
module rf_wb_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_BUS_W,
    parameter int unsigned DATA_W = REG_BUS_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic                         empty,
    output logic                         full,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_addr
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("rf_wb_fifo: DEPTH must be a power of two >= 2");
    end

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_d [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [DATA_W-1:0] mem_data_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push_ok, pop_ok;
    logic [PTR_W-1:0]  offs;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_addr = mem_addr_q[rd_ptr_q];
    assign head_data = mem_data_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (push_ok) begin
            mem_addr_d[wr_ptr_q] = push_addr;
            mem_data_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Pointer/occupancy registers; reset flushes the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are qualified by occupancy so no reset needed
    always_ff @(posedge clk) begin
        mem_addr_q <= mem_addr_d;
        mem_data_q <= mem_data_d;
    end

    // A slot is live when its distance from the read pointer is below the count
    always_comb begin
        offs = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs         = PTR_W'(i) - rd_ptr_q;
            ent_valid[i] = (CNT_W'(offs) < cnt_q);
            ent_addr[i]  = mem_addr_q[i];
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the register file's single write port between
// the ALU writeback (s0) and the load writeback (s1). Each source queues
// into its own rf_wb_fifo; s1 wins ties unless s0 has lost STARVE_LIMIT
// times in a row. The winning head drives registered w_ena/w_addr/w_data;
// writes to x0 are consumed without asserting w_ena.
// Optional feature macro: RF_WPORT_BYPASS_EN adds byp_hit1/2, byp_data1/2.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W       = REG_BUS_W,
    parameter int unsigned ADDR_W       = RF_ADDR_BUS_W,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input logic               clk,
    input logic               rst,
    rf_wport_arbiter_if.slave bus
);
    localparam int unsigned SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

    logic [ADDR_W-1:0]                head0_addr, head1_addr;
    logic [DATA_W-1:0]                head0_data, head1_data;
    logic                             empty0, empty1, full0, full1;
    logic [FIFO_DEPTH-1:0]            ent_valid0, ent_valid1;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_addr0, ent_addr1;
    logic                             head0_vld, head1_vld;
    grant_e                           grant;

    logic [SC_W-1:0]   starve_q, starve_d;
    logic              w_ena_q, w_ena_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic              pend1, pend2;

    rf_wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.s0_valid),
        .push_addr (bus.s0_addr),
        .push_data (bus.s0_data),
        .pop       (grant == GNT_S0),
        .head_addr (head0_addr),
        .head_data (head0_data),
        .empty     (empty0),
        .full      (full0),
        .ent_valid (ent_valid0),
        .ent_addr  (ent_addr0)
    );

    rf_wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.s1_valid),
        .push_addr (bus.s1_addr),
        .push_data (bus.s1_data),
        .pop       (grant == GNT_S1),
        .head_addr (head1_addr),
        .head_data (head1_data),
        .empty     (empty1),
        .full      (full1),
        .ent_valid (ent_valid1),
        .ent_addr  (ent_addr1)
    );

    assign head0_vld = !empty0;
    assign head1_vld = !empty1;

    // Fixed priority to s1, overridden once s0 has been starved long enough
    always_comb begin
        grant = GNT_NONE;
        if (head0_vld && head1_vld) begin
            grant = (starve_q == SC_MAX) ? GNT_S0 : GNT_S1;
        end else if (head0_vld) begin
            grant = GNT_S0;
        end else if (head1_vld) begin
            grant = GNT_S1;
        end
    end

    // Starvation count and write-port next state from the grant
    always_comb begin
        starve_d = starve_q;
        w_ena_d  = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (!head0_vld || grant == GNT_S0) begin
            starve_d = '0;
        end else if (grant == GNT_S1 && starve_q != SC_MAX) begin
            starve_d = starve_q + 1'b1;
        end
        case (grant)
            GNT_S0: begin
                w_ena_d  = (head0_addr != '0);
                w_addr_d = head0_addr;
                w_data_d = head0_data;
            end
            GNT_S1: begin
                w_ena_d  = (head1_addr != '0);
                w_addr_d = head1_addr;
                w_data_d = head1_data;
            end
            default: ;
        endcase
    end

    // Registered write port and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            w_ena_q  <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            starve_q <= starve_d;
            w_ena_q  <= w_ena_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    // Pending-write lookup against both FIFOs and the in-flight write
    always_comb begin
        pend1 = w_ena_q && (w_addr_q == bus.q_addr1);
        pend2 = w_ena_q && (w_addr_q == bus.q_addr2);
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid0[i] && ent_addr0[i] == bus.q_addr1) pend1 = 1'b1;
            if (ent_valid1[i] && ent_addr1[i] == bus.q_addr1) pend1 = 1'b1;
            if (ent_valid0[i] && ent_addr0[i] == bus.q_addr2) pend2 = 1'b1;
            if (ent_valid1[i] && ent_addr1[i] == bus.q_addr2) pend2 = 1'b1;
        end
        if (bus.q_addr1 == '0) pend1 = 1'b0;
        if (bus.q_addr2 == '0) pend2 = 1'b0;
    end

    assign bus.s0_ready = !full0;
    assign bus.s1_ready = !full1;
    assign bus.w_ena    = w_ena_q;
    assign bus.w_addr   = w_addr_q;
    assign bus.w_data   = w_data_q;
    assign bus.q_pend1  = pend1;
    assign bus.q_pend2  = pend2;
    assign bus.busy     = head0_vld || head1_vld || w_ena_q;

`ifdef RF_WPORT_BYPASS_EN
    assign bus.byp_hit1  = w_ena_q && (w_addr_q == bus.q_addr1) && (bus.q_addr1 != '0);
    assign bus.byp_hit2  = w_ena_q && (w_addr_q == bus.q_addr2) && (bus.q_addr2 != '0);
    assign bus.byp_data1 = w_data_q;
    assign bus.byp_data2 = w_data_q;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
// Define RF_WPORT_BYPASS_EN to also check the forwarding outputs.
module tb_rf_wport_arbiter;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned SL = 3;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t mq0[$];
    ent_t mq1[$];
    int unsigned   m_starve;
    logic          m_ena;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    rf_wport_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rf_wport_arbiter #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic bit m_pend(input logic [AW-1:0] q);
        bit hit = m_ena && (m_addr == q);
        foreach (mq0[i]) if (mq0[i].a == q) hit = 1'b1;
        foreach (mq1[i]) if (mq1[i].a == q) hit = 1'b1;
        return hit && (q != 0);
    endfunction

    function automatic bit m_busy();
        return (mq0.size() != 0) || (mq1.size() != 0) || m_ena;
    endfunction

    // Advance one clock edge: model follows the arbitration rules, then settle
    task automatic tick();
        bit h0, h1, acc0, acc1;
        int g;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            mq0.delete();
            mq1.delete();
            m_starve = 0;
            m_ena = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            h0 = mq0.size() > 0;
            h1 = mq1.size() > 0;
            acc0 = bus.s0_valid && (mq0.size() < DEPTH);
            acc1 = bus.s1_valid && (mq1.size() < DEPTH);
            g = 0;
            if (h0 && h1) g = (m_starve == SL) ? 1 : 2;
            else if (h0) g = 1;
            else if (h1) g = 2;
            if (!h0 || g == 1) m_starve = 0;
            else if (g == 2 && m_starve < SL) m_starve = m_starve + 1;
            m_ena = 1'b0;
            if (g == 1) begin
                e = mq0.pop_front();
                m_ena = (e.a != 0); m_addr = e.a; m_data = e.d;
            end else if (g == 2) begin
                e = mq1.pop_front();
                m_ena = (e.a != 0); m_addr = e.a; m_data = e.d;
            end
            if (acc0) begin e.a = bus.s0_addr; e.d = bus.s0_data; mq0.push_back(e); end
            if (acc1) begin e.a = bus.s1_addr; e.d = bus.s1_data; mq1.push_back(e); end
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.s0_valid = 1'b0; bus.s0_addr = '0; bus.s0_data = '0;
        bus.s1_valid = 1'b0; bus.s1_addr = '0; bus.s1_data = '0;
        bus.q_addr1 = '0; bus.q_addr2 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.w_ena !== 1'b0) begin errors++; $display("FAIL reset_w_ena got %b want 0", bus.w_ena); end
        checks++; if (bus.w_addr !== 5'd0) begin errors++; $display("FAIL reset_w_addr got %0d want 0", bus.w_addr); end
        checks++; if (bus.w_data !== 64'd0) begin errors++; $display("FAIL reset_w_data got %h want 0", bus.w_data); end
        checks++; if (bus.s0_ready !== 1'b1 || bus.s1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b want 11", bus.s0_ready, bus.s1_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        do_reset();
        bus.s0_valid = 1'b1; bus.s0_addr = 5'd5; bus.s0_data = 64'h1234;
        tick();
        idle_inputs();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_q got %b want 1", bus.busy); end
        tick();
        checks++; if (bus.w_ena !== 1'b1) begin errors++; $display("FAIL single_w_ena got %b want 1", bus.w_ena); end
        checks++; if (bus.w_addr !== 5'd5) begin errors++; $display("FAIL single_w_addr got %0d want 5", bus.w_addr); end
        checks++; if (bus.w_data !== 64'h1234) begin errors++; $display("FAIL single_w_data got %h want 1234", bus.w_data); end
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.w_ena !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b w_ena=%b want 0 0", bus.busy, bus.w_ena); end
    endtask

    task automatic test_x0();
        do_reset();
        bus.s0_valid = 1'b1; bus.s0_addr = 5'd0; bus.s0_data = 64'hFFFF;
        tick();
        idle_inputs();
        checks++; if (bus.s0_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b want 1", bus.s0_ready); end
        tick();
        checks++; if (bus.w_ena !== 1'b0) begin errors++; $display("FAIL x0_w_ena got %b want 0", bus.w_ena); end
        checks++; if (bus.w_data !== 64'hFFFF || bus.w_addr !== 5'd0) begin errors++; $display("FAIL x0_w_port got addr=%0d data=%h want 0 ffff", bus.w_addr, bus.w_data); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL x0_busy got %b want 0", bus.busy); end
    endtask

    // Both sources push every cycle: s1 wins three times, then s0 is forced
    task automatic test_starve();
        bit exp_s0;
        do_reset();
        for (int k = 1; k <= 22; k++) begin
            bus.s0_valid = 1'b1; bus.s0_addr = AW'(1 + (k % 15)); bus.s0_data = {32'hA0A0_0000, 32'(k)};
            bus.s1_valid = 1'b1; bus.s1_addr = AW'(16 + (k % 16)); bus.s1_data = {32'hB1B1_0000, 32'(k)};
            tick();
            checks++; if (bus.w_ena !== m_ena || bus.w_addr !== m_addr || bus.w_data !== m_data) begin
                errors++; $display("FAIL starve_wport k=%0d got %b/%0d/%h want %b/%0d/%h", k, bus.w_ena, bus.w_addr, bus.w_data, m_ena, m_addr, m_data);
            end
            if (k >= 2) begin
                exp_s0 = ((k - 2) % 4) == 3;
                checks++; if (bus.w_ena !== 1'b1 || (bus.w_addr < 5'd16) !== exp_s0) begin
                    errors++; $display("FAIL starve_pattern k=%0d got addr=%0d want source s%0d", k, bus.w_addr, exp_s0 ? 0 : 1);
                end
            end
            if (k >= 5 && ((k - 2) % 4) == 3) begin
                checks++; if (bus.s1_ready !== 1'b0) begin errors++; $display("FAIL fill_s1_full k=%0d got %b want 0", k, bus.s1_ready); end
            end
            if (k >= 6 && ((k - 2) % 4) == 0) begin
                checks++; if (bus.s1_ready !== 1'b1) begin errors++; $display("FAIL fill_s1_free k=%0d got %b want 1", k, bus.s1_ready); end
            end
        end
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (bus.w_ena !== m_ena || bus.w_addr !== m_addr || bus.w_data !== m_data) begin
                errors++; $display("FAIL starve_drain k=%0d got %b/%0d/%h want %b/%0d/%h", k, bus.w_ena, bus.w_addr, bus.w_data, m_ena, m_addr, m_data);
            end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL starve_drained got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_hazard();
        do_reset();
        bus.q_addr1 = 5'd7;
        bus.s1_valid = 1'b1; bus.s1_addr = 5'd7; bus.s1_data = 64'h77;
        #1;
        checks++; if (bus.q_pend1 !== 1'b0) begin errors++; $display("FAIL haz_same_cycle got %b want 0", bus.q_pend1); end
        tick();
        bus.s1_valid = 1'b0;
        #1;
        checks++; if (bus.q_pend1 !== 1'b1 || bus.w_ena !== 1'b0) begin errors++; $display("FAIL haz_queued got pend=%b w_ena=%b want 1 0", bus.q_pend1, bus.w_ena); end
        tick();
        checks++; if (bus.q_pend1 !== 1'b1 || bus.w_ena !== 1'b1 || bus.w_addr !== 5'd7) begin errors++; $display("FAIL haz_inflight got pend=%b w_ena=%b addr=%0d want 1 1 7", bus.q_pend1, bus.w_ena, bus.w_addr); end
`ifdef RF_WPORT_BYPASS_EN
        checks++; if (bus.byp_hit1 !== 1'b1 || bus.byp_data1 !== 64'h77) begin errors++; $display("FAIL byp_hit got hit=%b data=%h want 1 77", bus.byp_hit1, bus.byp_data1); end
`endif
        tick();
        checks++; if (bus.q_pend1 !== 1'b0 || bus.w_ena !== 1'b0) begin errors++; $display("FAIL haz_retired got pend=%b w_ena=%b want 0 0", bus.q_pend1, bus.w_ena); end
`ifdef RF_WPORT_BYPASS_EN
        checks++; if (bus.byp_hit1 !== 1'b0) begin errors++; $display("FAIL byp_clear got %b want 0", bus.byp_hit1); end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.s0_valid = 1'b1; bus.s0_addr = 5'd9;  bus.s0_data = 64'h99;
        bus.s1_valid = 1'b1; bus.s1_addr = 5'd10; bus.s1_data = 64'hAA;
        tick();
        tick();
        idle_inputs();
        bus.q_addr1 = 5'd9; bus.q_addr2 = 5'd10;
        #1;
        checks++; if (bus.q_pend1 !== 1'b1 || bus.q_pend2 !== 1'b1) begin errors++; $display("FAIL mrst_pre got %b%b want 11", bus.q_pend1, bus.q_pend2); end
        rst = 1'b1;
        tick();
        checks++; if (bus.w_ena !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mrst_flush got w_ena=%b busy=%b want 0 0", bus.w_ena, bus.busy); end
        checks++; if (bus.q_pend1 !== 1'b0 || bus.q_pend2 !== 1'b0) begin errors++; $display("FAIL mrst_pend got %b%b want 00", bus.q_pend1, bus.q_pend2); end
        rst = 1'b0;
        tick();
        checks++; if (bus.w_ena !== 1'b0) begin errors++; $display("FAIL mrst_no_write got %b want 0", bus.w_ena); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            bus.s0_valid = ($urandom_range(0, 3) != 0);
            bus.s1_valid = ($urandom_range(0, 2) != 0);
            bus.s0_addr = AW'($urandom_range(0, 7));
            bus.s1_addr = AW'($urandom_range(0, 7));
            bus.s0_data = {$urandom(), $urandom()};
            bus.s1_data = {$urandom(), $urandom()};
            bus.q_addr1 = AW'($urandom_range(0, 7));
            bus.q_addr2 = AW'($urandom_range(0, 7));
            #1;
            checks++; if (bus.s0_ready !== (mq0.size() < DEPTH) || bus.s1_ready !== (mq1.size() < DEPTH)) begin
                errors++; $display("FAIL rnd_ready n=%0d got %b%b want %b%b", n, bus.s0_ready, bus.s1_ready, mq0.size() < DEPTH, mq1.size() < DEPTH);
            end
            checks++; if (bus.q_pend1 !== m_pend(bus.q_addr1) || bus.q_pend2 !== m_pend(bus.q_addr2)) begin
                errors++; $display("FAIL rnd_pend n=%0d got %b%b want %b%b", n, bus.q_pend1, bus.q_pend2, m_pend(bus.q_addr1), m_pend(bus.q_addr2));
            end
            checks++; if (bus.busy !== m_busy()) begin errors++; $display("FAIL rnd_busy n=%0d got %b want %b", n, bus.busy, m_busy()); end
`ifdef RF_WPORT_BYPASS_EN
            checks++; if (bus.byp_hit1 !== (m_ena && m_addr == bus.q_addr1 && bus.q_addr1 != 0) || bus.byp_data1 !== m_data) begin
                errors++; $display("FAIL rnd_byp n=%0d got %b/%h want %b/%h", n, bus.byp_hit1, bus.byp_data1, m_ena && m_addr == bus.q_addr1 && bus.q_addr1 != 0, m_data);
            end
`endif
            tick();
            checks++; if (bus.w_ena !== m_ena || bus.w_addr !== m_addr || bus.w_data !== m_data) begin
                errors++; $display("FAIL rnd_wport n=%0d got %b/%0d/%h want %b/%0d/%h", n, bus.w_ena, bus.w_addr, bus.w_data, m_ena, m_addr, m_data);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_x0();
        test_starve();
        test_hazard();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
